// File: rtl/mult_share_arbiter.sv
// mult_share_arbiter: round-robin sharing of one 4-bit signed multiplier
// between two requesters, with a settle window before result capture.
//
// Ports:
//   clock, reset_n              rising-edge clock, async active-low reset
//   reqX_valid/ready/a/b        request channel of port X (X = 0,1)
//   rspX_valid/ready/prod/ovf   response channel of port X
//   busy                        high whenever the controller is not idle
//   gnt0_count, gnt1_count      per-port grant counters, present only
//                               when MULT_SHARE_ARB_STATS_EN is defined
// Parameters:
//   WAIT_CYCLES  cycles operands are held at the multiplier (1..15)
//   CNT_W        grant counter width (stats build only)
module mult_share_arbiter #(
  parameter int WAIT_CYCLES = 2,
  parameter int CNT_W       = 8
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [3:0]       req0_a,
  input  logic [3:0]       req0_b,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [3:0]       req1_a,
  input  logic [3:0]       req1_b,
  output logic             rsp0_valid,
  input  logic             rsp0_ready,
  output logic [3:0]       rsp0_prod,
  output logic             rsp0_ovf,
  output logic             rsp1_valid,
  input  logic             rsp1_ready,
  output logic [3:0]       rsp1_prod,
  output logic             rsp1_ovf,
`ifdef MULT_SHARE_ARB_STATS_EN
  output logic [CNT_W-1:0] gnt0_count,
  output logic [CNT_W-1:0] gnt1_count,
`endif
  output logic             busy
);

  if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15 || CNT_W < 1)
  begin : g_bad_param
    $error("mult_share_arbiter: illegal parameter value");
  end

  localparam logic [3:0] WaitInit = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    RESP
  } state_e;

  state_e     state_q;
  logic       last_q;
  logic       owner_q;
  logic [3:0] op_a_q;
  logic [3:0] op_b_q;
  logic [3:0] cnt_q;
  logic       busy_q;

  logic       r0_vld_q;
  logic [3:0] r0_prod_q;
  logic       r0_ovf_q;
  logic       r1_vld_q;
  logic [3:0] r1_prod_q;
  logic       r1_ovf_q;

  // Arbitration
  logic       take_en;
  logic       gnt_any;
  logic       gnt_port;
  logic       acc;
  logic [3:0] sel_a;
  logic [3:0] sel_b;

  // Requests are only offered a grant while idle; reset_n gates
  // the combinational ready so it is low during reset.
  assign take_en = reset_n && (state_q == IDLE);

  always_comb begin
    gnt_any  = req0_valid | req1_valid;
    gnt_port = 1'b0;
    unique case (1'b1)
      (req0_valid && req1_valid):  gnt_port = ~last_q;
      (req1_valid && !req0_valid): gnt_port = 1'b1;
      default:                     gnt_port = 1'b0;
    endcase
  end

  assign req0_ready = take_en && req0_valid && !gnt_port;
  assign req1_ready = take_en && req1_valid && gnt_port;
  assign acc        = take_en && gnt_any;
  assign sel_a      = gnt_port ? req1_a : req0_a;
  assign sel_b      = gnt_port ? req1_b : req0_b;

  // Shared multiplier, fed only from the operand registers.
  // The true product is within -64..64, so 8 bits hold it.
  logic signed [7:0] mul_full;
  logic        [3:0] mul_prod;
  logic              mul_ovf;

  always_comb begin
    mul_full = $signed({{4{op_a_q[3]}}, op_a_q})
             * $signed({{4{op_b_q[3]}}, op_b_q});
    mul_prod = mul_full[3:0];
    // Fits in 4 bits only if bits 7..3 are a pure sign extension.
    mul_ovf  = (mul_full[7:3] != {5{mul_full[3]}});
  end

  logic rsp_hs;
  assign rsp_hs = owner_q ? (r1_vld_q && rsp1_ready)
                          : (r0_vld_q && rsp0_ready);

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      last_q    <= 1'b1;
      owner_q   <= 1'b0;
      op_a_q    <= '0;
      op_b_q    <= '0;
      cnt_q     <= '0;
      busy_q    <= 1'b0;
      r0_vld_q  <= 1'b0;
      r0_prod_q <= '0;
      r0_ovf_q  <= 1'b0;
      r1_vld_q  <= 1'b0;
      r1_prod_q <= '0;
      r1_ovf_q  <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (acc) begin
            op_a_q  <= sel_a;
            op_b_q  <= sel_b;
            owner_q <= gnt_port;
            last_q  <= gnt_port;
            cnt_q   <= WaitInit;
            busy_q  <= 1'b1;
            state_q <= CALC;
          end
        end
        CALC: begin
          cnt_q <= cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            if (owner_q) begin
              r1_vld_q  <= 1'b1;
              r1_prod_q <= mul_prod;
              r1_ovf_q  <= mul_ovf;
            end else begin
              r0_vld_q  <= 1'b1;
              r0_prod_q <= mul_prod;
              r0_ovf_q  <= mul_ovf;
            end
            state_q <= RESP;
          end
        end
        RESP: begin
          if (rsp_hs) begin
            r0_vld_q <= 1'b0;
            r1_vld_q <= 1'b0;
            busy_q   <= 1'b0;
            state_q  <= IDLE;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign rsp0_valid = r0_vld_q;
  assign rsp0_prod  = r0_prod_q;
  assign rsp0_ovf   = r0_ovf_q;
  assign rsp1_valid = r1_vld_q;
  assign rsp1_prod  = r1_prod_q;
  assign rsp1_ovf   = r1_ovf_q;
  assign busy       = busy_q;

`ifdef MULT_SHARE_ARB_STATS_EN
  logic [CNT_W-1:0] gnt0_q;
  logic [CNT_W-1:0] gnt1_q;

  // Counters wrap naturally at all-ones.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      gnt0_q <= '0;
      gnt1_q <= '0;
    end else if (acc) begin
      if (gnt_port) begin
        gnt1_q <= gnt1_q + 1'b1;
      end else begin
        gnt0_q <= gnt0_q + 1'b1;
      end
    end
  end

  assign gnt0_count = gnt0_q;
  assign gnt1_count = gnt1_q;
`endif

endmodule

// File: tb/tb_mult_share_arbiter.sv
// tb_mult_share_arbiter: directed + randomized checks of
// mult_share_arbiter against a behavioural model.
module tb_mult_share_arbiter;

  localparam int W  = 2;
  localparam int CW = 2;

  logic       clock = 1'b0;
  logic       reset_n;
  logic       req0_valid, req0_ready;
  logic [3:0] req0_a, req0_b;
  logic       req1_valid, req1_ready;
  logic [3:0] req1_a, req1_b;
  logic       rsp0_valid, rsp0_ready;
  logic [3:0] rsp0_prod;
  logic       rsp0_ovf;
  logic       rsp1_valid, rsp1_ready;
  logic [3:0] rsp1_prod;
  logic       rsp1_ovf;
  logic       busy;
`ifdef MULT_SHARE_ARB_STATS_EN
  logic [CW-1:0] gnt0_count, gnt1_count;
`endif

  mult_share_arbiter #(
    .WAIT_CYCLES(W),
    .CNT_W      (CW)
  ) dut (
    .clock     (clock),
    .reset_n   (reset_n),
    .req0_valid(req0_valid),
    .req0_ready(req0_ready),
    .req0_a    (req0_a),
    .req0_b    (req0_b),
    .req1_valid(req1_valid),
    .req1_ready(req1_ready),
    .req1_a    (req1_a),
    .req1_b    (req1_b),
    .rsp0_valid(rsp0_valid),
    .rsp0_ready(rsp0_ready),
    .rsp0_prod (rsp0_prod),
    .rsp0_ovf  (rsp0_ovf),
    .rsp1_valid(rsp1_valid),
    .rsp1_ready(rsp1_ready),
    .rsp1_prod (rsp1_prod),
    .rsp1_ovf  (rsp1_ovf),
`ifdef MULT_SHARE_ARB_STATS_EN
    .gnt0_count(gnt0_count),
    .gnt1_count(gnt1_count),
`endif
    .busy      (busy)
  );

  always #5 clock = ~clock;

  int   n_vec  = 0;
  int   n_miss = 0;
  logic last_m = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_miss++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: ovf in bit 4, low product nibble in bits 3:0.
  function automatic logic [4:0] model(input logic [3:0] a,
                                       input logic [3:0] b);
    int x;
    x = int'($signed(a)) * int'($signed(b));
    return {(x < -8 || x > 7), x[3:0]};
  endfunction

  function automatic logic rdy_of(input int p);
    return (p == 0) ? req0_ready : req1_ready;
  endfunction

  function automatic logic vld_of(input int p);
    return (p == 0) ? rsp0_valid : rsp1_valid;
  endfunction

  function automatic logic [4:0] rsp_of(input int p);
    return (p == 0) ? {rsp0_ovf, rsp0_prod} : {rsp1_ovf, rsp1_prod};
  endfunction

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic drive(input int p, input logic v,
                       input logic [3:0] a, input logic [3:0] b);
    if (p == 0) begin
      req0_valid = v; req0_a = a; req0_b = b;
    end else begin
      req1_valid = v; req1_a = a; req1_b = b;
    end
  endtask

  task automatic do_reset();
    reset_n    = 1'b0;
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    #2;
    reset_n = 1'b1;
    last_m  = 1'b1;
    cyc();
  endtask

  // One complete transaction on port p with only p requesting.
  task automatic serve(input int p, input logic [3:0] a,
                       input logic [3:0] b, input string tag);
    logic [4:0] e;
    e = model(a, b);
    drive(p, 1'b1, a, b);
    #1;
    chk({tag, ".ready"}, rdy_of(p), 1);
    chk({tag, ".ready_other"}, rdy_of(1 - p), 0);
    cyc();
    drive(p, 1'b0, a, b);
    last_m = (p != 0);
    chk({tag, ".busy"}, busy, 1);
    chk({tag, ".early0"}, vld_of(p), 0);
    for (int k = 1; k < W; k++) begin
      cyc();
      chk({tag, ".early"}, vld_of(p), 0);
    end
    cyc();
    chk({tag, ".valid"}, vld_of(p), 1);
    chk({tag, ".result"}, rsp_of(p), e);
    chk({tag, ".other_valid"}, vld_of(1 - p), 0);
    cyc();
    chk({tag, ".valid_drop"}, vld_of(p), 0);
    chk({tag, ".idle"}, busy, 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [3:0] ta [5];
    logic [3:0] tb [5];
    logic [3:0] ca [2];
    logic [3:0] cb [2];
    logic [4:0] e;
    logic [4:0] e1;

    // Reset state, with both requesters already asserting valid.
    reset_n    = 1'b0;
    req0_valid = 1'b1; req0_a = 4'h3; req0_b = 4'h2;
    req1_valid = 1'b1; req1_a = 4'h1; req1_b = 4'h1;
    rsp0_ready = 1'b1;
    rsp1_ready = 1'b1;
    #2;
    chk("rst.req0_ready", req0_ready, 0);
    chk("rst.req1_ready", req1_ready, 0);
    chk("rst.busy", busy, 0);
    chk("rst.rsp0_valid", rsp0_valid, 0);
    chk("rst.rsp1_valid", rsp1_valid, 0);
    chk("rst.rsp0", {rsp0_ovf, rsp0_prod}, 0);
    chk("rst.rsp1", {rsp1_ovf, rsp1_prod}, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    #5;
    reset_n = 1'b1;
    cyc();

    // Single request 3*2.
    serve(0, 4'h3, 4'h2, "single");

    // Extremes on a randomly chosen port.
    ta = '{4'h3, 4'hE, 4'h8, 4'h8, 4'h8};
    tb = '{4'h3, 4'h3, 4'h1, 4'h8, 4'hF};
    for (int i = 0; i < 5; i++) begin
      serve(int'($urandom_range(0, 1)), ta[i], tb[i], "extreme");
    end

    // Random single transactions.
    for (int i = 0; i < 12; i++) begin
      serve(int'($urandom_range(0, 1)), 4'($urandom),
            4'($urandom), "random");
    end

    // Contention from reset, both requesters continuously valid.
    do_reset();
    for (int p = 0; p < 2; p++) begin
      ca[p] = 4'($urandom);
      cb[p] = 4'($urandom);
      drive(p, 1'b1, ca[p], cb[p]);
    end
    for (int t = 0; t < 4; t++) begin
      int g;
      g = last_m ? 0 : 1;
      #1;
      chk("cont.req0_ready", req0_ready, (g == 0));
      chk("cont.req1_ready", req1_ready, (g == 1));
      e = model(ca[g], cb[g]);
      cyc();
      last_m = (g != 0);
      ca[g] = 4'($urandom);
      cb[g] = 4'($urandom);
      drive(g, 1'b1, ca[g], cb[g]);
      chk("cont.hold0", req0_ready, 0);
      chk("cont.hold1", req1_ready, 0);
      for (int k = 1; k < W; k++) cyc();
      chk("cont.early", vld_of(g), 0);
      cyc();
      chk("cont.valid", vld_of(g), 1);
      chk("cont.result", rsp_of(g), e);
      chk("cont.other", vld_of(1 - g), 0);
      cyc();
      chk("cont.drop", vld_of(g), 0);
    end
    drive(0, 1'b0, 4'h0, 4'h0);
    drive(1, 1'b0, 4'h0, 4'h0);
    cyc();

    // Backpressure on port 1 while port 0 waits.
    rsp1_ready = 1'b0;
    ca[1] = 4'($urandom);
    cb[1] = 4'($urandom);
    e1 = model(ca[1], cb[1]);
    drive(1, 1'b1, ca[1], cb[1]);
    #1;
    chk("bp.req1_ready", req1_ready, 1);
    cyc();
    last_m = 1'b1;
    drive(1, 1'b0, ca[1], cb[1]);
    ca[0] = 4'($urandom);
    cb[0] = 4'($urandom);
    e = model(ca[0], cb[0]);
    drive(0, 1'b1, ca[0], cb[0]);
    #1;
    chk("bp.req0_blocked", req0_ready, 0);
    for (int k = 0; k < W; k++) cyc();
    for (int k = 0; k < 5; k++) begin
      chk("bp.rsp1_valid", rsp1_valid, 1);
      chk("bp.rsp1_hold", {rsp1_ovf, rsp1_prod}, e1);
      chk("bp.req0_ready", req0_ready, 0);
      chk("bp.rsp0_valid", rsp0_valid, 0);
      cyc();
    end
    rsp1_ready = 1'b1;
    #1;
    chk("bp.req0_pre_hs", req0_ready, 0);
    cyc();
    chk("bp.rsp1_done", rsp1_valid, 0);
    chk("bp.req0_after", req0_ready, 1);
    cyc();
    last_m = 1'b0;
    drive(0, 1'b0, ca[0], cb[0]);
    chk("bp.accept0", busy, 1);
    for (int k = 0; k < W; k++) cyc();
    chk("bp.rsp0_valid2", rsp0_valid, 1);
    chk("bp.rsp0_result", {rsp0_ovf, rsp0_prod}, e);
    cyc();
    chk("bp.rsp0_drop", rsp0_valid, 0);

    // Reset one cycle after an accept.
    drive(0, 1'b1, 4'h3, 4'h3);
    #1;
    chk("rmid.ready", req0_ready, 1);
    cyc();
    drive(0, 1'b0, 4'h3, 4'h3);
    cyc();
    reset_n    = 1'b0;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    #1;
    chk("rmid.busy", busy, 0);
    chk("rmid.rsp0_valid", rsp0_valid, 0);
    chk("rmid.rsp1_valid", rsp1_valid, 0);
    chk("rmid.rsp0", {rsp0_ovf, rsp0_prod}, 0);
    chk("rmid.rsp1", {rsp1_ovf, rsp1_prod}, 0);
    chk("rmid.req0_ready", req0_ready, 0);
    chk("rmid.req1_ready", req1_ready, 0);
    req0_valid = 1'b0;
    req1_valid = 1'b0;
    cyc();
    #2;
    reset_n = 1'b1;
    last_m  = 1'b1;
    for (int k = 0; k < W + 3; k++) begin
      cyc();
      chk("rmid.no_rsp0", rsp0_valid, 0);
      chk("rmid.no_rsp1", rsp1_valid, 0);
    end
    serve(0, 4'($urandom), 4'($urandom), "after_rst");

`ifdef MULT_SHARE_ARB_STATS_EN
    do_reset();
    chk("stats.rst0", gnt0_count, 0);
    chk("stats.rst1", gnt1_count, 0);
    for (int i = 0; i < 5; i++) begin
      serve(0, 4'($urandom), 4'($urandom), "stats");
      chk("stats.gnt0", gnt0_count, (i + 1) % (1 << CW));
      chk("stats.gnt1", gnt1_count, 0);
    end
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/mult_share_arbiter.md
Name: mult_share_arbiter

Overview:
- Two-requester controller that time-shares one 4-bit signed array multiplier (4-bit product, overflow flag).
- Arbitrates round-robin and registers operands.
- Holds them stable for a programmable settle window, then captures product and overflow into a result register.
- Returns the result to the granted requester over a valid/ready handshake; sits between core-side issue logic and the shared multiplier datapath.

Parameters:
- WAIT_CYCLES, 2, cycles operands are held at the multiplier before capture; legal 1..15
- CNT_W, 8, width of per-port grant counters (optional feature only)

Ports:
- clock  in  1  system clock, rising edge
- reset_n  in  1  asynchronous active-low reset
- req0_valid  in  1  port 0 request valid
- req0_ready  out  1  port 0 request accepted this cycle
- req0_a  in  4  port 0 signed multiplicand
- req0_b  in  4  port 0 signed multiplier
- req1_valid  in  1  port 1 request valid
- req1_ready  out  1  port 1 request accepted
- req1_a  in  4  port 1 signed multiplicand
- req1_b  in  4  port 1 signed multiplier
- rsp0_valid  out  1  port 0 result valid
- rsp0_ready  in  1  port 0 result consumed
- rsp0_prod  out  4  port 0 product, low 4 bits
- rsp0_ovf  out  1  port 0 overflow
- rsp1_valid  out  1  port 1 result valid
- rsp1_ready  in  1  port 1 result consumed
- rsp1_prod  out  4  port 1 product
- rsp1_ovf  out  1  port 1 overflow
- busy  out  1  high in any state other than IDLE

Behaviour:
- Clock and reset: one clock, clock; reset_n asynchronous, active-low.
- Reset values:
  - State = IDLE; all ready/valid = 0; rspX_prod = 0, rspX_ovf = 0; busy = 0.
  - Round-robin pointer last = 1, so port 0 wins the first tie.
  - Operand, result and owner registers = 0.
- FSM states: IDLE, CALC, RESP.
- IDLE:
  - Grant is combinational: only req0 valid -> port 0; only req1 valid -> port 1; both valid -> the port != last.
  - reqX_ready = 1 only for the granted port and only in IDLE.
  - On valid&&ready: latch a/b into operand regs, owner <= port, last <= port, counter <= WAIT_CYCLES, go CALC.
  - With no valid request, stay in IDLE.
- CALC:
  - Multiplier inputs are driven solely from operand regs.
  - Counter decrements each cycle; on the cycle counter == 1, capture multiplier product/ovf into the result reg and go RESP.
- RESP:
  - rsp<owner>_valid = 1; the other port's valid stays 0.
  - prod/ovf are stable while valid && !ready.
  - On rsp valid&&ready, go IDLE. No new grant in the same cycle; the next accept is at the earliest 1 cycle after the response handshake.
- Latency: request accepted at edge N -> rsp_valid first high after edge N+WAIT_CYCLES.
- Arithmetic:
  - Operands are two's complement, -8..7.
  - prod = low 4 bits of the true product.
  - ovf = 1 iff the true product is outside -8..7.
- Requests arriving while busy see ready = 0 and must hold; no queuing, no drop.
- A requester deasserting valid before ready is legal; nothing is latched.
- reset_n low mid-operation: immediate return to reset values; the in-flight result is discarded and never presented.
- rspX_prod/ovf of the non-owner port keep their last values; they are meaningful only with valid.

Optional Feature:
- Macro: MULT_SHARE_ARB_STATS_EN.
- Defined:
  - Adds outputs gnt0_count and gnt1_count [CNT_W-1:0].
  - Each increments on its port's request handshake, wraps from all-ones to 0, and resets to 0.
- Undefined: ports and counters absent; all other behaviour identical.

Test Plan:
- Single request: port 0 a=3, b=2, WAIT_CYCLES=2, rsp0_ready=1 -> rsp0_valid 2 cycles after accept; prod=4'b0110, ovf=0; rsp1_valid stays 0.
- Overflow and extremes:
  - 3*3 -> prod=4'b1001, ovf=1
  - -2*3 -> 4'b1010, ovf=0
  - -8*1 -> 4'b1000, ovf=0
  - -8*-8 -> 4'b0000, ovf=1
  - -8*-1 -> 4'b1000, ovf=1
- Contention: both valid from reset, continuously -> grant order 0,1,0,1; each port's results match its own operands.
- Backpressure: rsp1_ready held 0 for 5 cycles -> rsp1_valid/prod/ovf stable; req0_ready stays 0 throughout; port 0 is accepted 1 cycle after the rsp1 handshake.
- Reset mid-CALC: assert reset_n low 1 cycle after accept -> all outputs 0 asynchronously; after release no rsp_valid appears; the next request is served normally.
- With MULT_SHARE_ARB_STATS_EN, CNT_W=2: 5 port-0 grants -> gnt0_count sequence 1,2,3,0,1; gnt1_count=0.
